// File: rtl/delay_line_ctrl.sv
// Runtime-programmable delay line: a circular buffer over a dual-port RAM.
// Output samples are qualified so stale RAM contents from an earlier configuration never escape.

module ram #(
   parameter int DATA_WIDTH = 25,
   parameter int DEPTH      = 512,
   localparam int ADDR_W    = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

module delay_line_ctrl #(
   parameter int  DATA_WIDTH = 25,
   parameter int  MAX_LEN    = 512,
   localparam int LEN_W      = $clog2(MAX_LEN)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_load,
   input  logic [LEN_W-1:0]      cfg_len,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  primed,
   output logic                  cfg_err,
   output logic                  drop
);

   typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

   localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

   state_t                  state_q;
   state_t                  state_d;
   logic [LEN_W-1:0]        delay_q;
   logic [LEN_W-1:0]        wr_ptr_q;
   logic [LEN_W-1:0]        fill_q;
   logic [LEN_W-1:0]        wr_ptr_inc;
   logic [LEN_W-1:0]        fill_inc;
   logic                    cfg_ok;
   logic                    accept;
   logic                    out_valid_q;
   logic                    cfg_err_q;
   logic                    drop_q;
   logic [DATA_WIDTH-1:0]   ram_rd_data;

   assign cfg_ok   = cfg_load && (cfg_len != '0);
   assign accept   = in_valid && (state_q != IDLE) && !cfg_ok;
   assign fill_inc = fill_q + ONE;

   // Modulus is delay+1; wrap by comparing with the delay, not by power-of-two rollover.
   assign wr_ptr_inc = (wr_ptr_q == delay_q) ? '0 : wr_ptr_q + ONE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (cfg_ok) begin
         state_d = FILL;
      end else if (accept && (state_q == FILL) && (fill_inc == delay_q)) begin
         state_d = RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         delay_q     <= '0;
         wr_ptr_q    <= '0;
         fill_q      <= '0;
         out_valid_q <= 1'b0;
         cfg_err_q   <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         cfg_err_q   <= cfg_load && (cfg_len == '0);
         drop_q      <= in_valid && ((state_q == IDLE) || cfg_ok);
         out_valid_q <= accept && (state_q == RUN);
         if (cfg_ok) begin
            delay_q  <= cfg_len;
            wr_ptr_q <= '0;
            fill_q   <= '0;
         end else if (accept) begin
            wr_ptr_q <= wr_ptr_inc;
            if (fill_q != delay_q) begin
               fill_q <= fill_inc;
            end
         end
      end
   end

   // The slot just ahead of the write pointer holds the sample written D accepts ago.
   ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (MAX_LEN)
   ) u_ram (
      .clk     (clk),
      .wr_en   (accept),
      .wr_addr (wr_ptr_q),
      .wr_data (in_data),
      .rd_en   (accept),
      .rd_addr (wr_ptr_inc),
      .rd_data (ram_rd_data)
   );

   assign out_valid = out_valid_q;
   assign out_data  = out_valid_q ? ram_rd_data : '0;
   assign primed    = (state_q == RUN);
   assign cfg_err   = cfg_err_q;
   assign drop      = drop_q;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Self-checking bench for delay_line_ctrl: queue-based reference model plus directed literal checks
// and randomized stimulus.

module tb_delay_line_ctrl;

   localparam int DW = 25;
   localparam int LW = 9;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          cfg_load = 1'b0;
   logic [LW-1:0] cfg_len = '0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          primed;
   logic          cfg_err;
   logic          drop;

   int tests = 0;
   int fails = 0;

   // Reference model state: samples accepted since last configuration (at most D kept).
   logic [DW-1:0] hist[$];
   int            model_d = 0;
   bit            configured = 0;
   logic          exp_valid = 0;
   logic [DW-1:0] exp_data = '0;
   logic          exp_primed = 0;
   logic          exp_cfg_err = 0;
   logic          exp_drop = 0;

   delay_line_ctrl #(.DATA_WIDTH(DW), .MAX_LEN(512)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_load  (cfg_load),
      .cfg_len   (cfg_len),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .primed    (primed),
      .cfg_err   (cfg_err),
      .drop      (drop)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic ld,
                                input logic [LW-1:0] len);
      in_valid = v;
      in_data  = d;
      cfg_load = ld;
      cfg_len  = len;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      cfg_load = 1'b0;
   endtask

   // Behavioural model: an accept returns the sample D accepts earlier once D are buffered.
   initial begin
      bit acc_cfg;
      bit accept;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            hist.delete();
            model_d     = 0;
            configured  = 0;
            exp_valid   = 0;
            exp_data    = '0;
            exp_primed  = 0;
            exp_cfg_err = 0;
            exp_drop    = 0;
         end else begin
            acc_cfg     = cfg_load && (cfg_len != 0);
            accept      = in_valid && configured && !acc_cfg;
            exp_cfg_err = cfg_load && (cfg_len == 0);
            exp_drop    = in_valid && (!configured || acc_cfg);
            exp_valid   = 0;
            exp_data    = '0;
            if (accept) begin
               if (hist.size() == model_d) begin
                  exp_valid = 1;
                  exp_data  = hist[0];
               end
               hist.push_back(in_data);
               if (hist.size() > model_d) void'(hist.pop_front());
            end
            if (acc_cfg) begin
               configured = 1;
               model_d    = int'(cfg_len);
               hist.delete();
            end
            exp_primed = configured && (hist.size() == model_d);
         end
      end
   end

   // Compare process: every output, every cycle.
   initial begin
      forever begin
         @(negedge clk);
         checkOutput("model_out_valid", 32'(out_valid), 32'(exp_valid));
         checkOutput("model_out_data", 32'(out_data), 32'(exp_data));
         checkOutput("model_primed", 32'(primed), 32'(exp_primed));
         checkOutput("model_cfg_err", 32'(cfg_err), 32'(exp_cfg_err));
         checkOutput("model_drop", 32'(drop), 32'(exp_drop));
      end
   end

   initial begin
      logic v;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_out_valid", 32'(out_valid), 0);
      checkOutput("reset_primed", 32'(primed), 0);
      rst_n = 1'b1;

      // In IDLE every sample is dropped and nothing comes out.
      applyStimulus(1, 25'd77, 0, 0);
      checkOutput("idle_drop", 32'(drop), 1);
      checkOutput("idle_out_valid", 32'(out_valid), 0);

      // D=4 ramp
      applyStimulus(0, 0, 1, 9'd4);
      for (int n = 1; n <= 12; n++) begin
         applyStimulus(1, DW'(n), 0, 0);
         checkOutput("d4_out_valid", 32'(out_valid), (n >= 5) ? 1 : 0);
         checkOutput("d4_out_data", 32'(out_data), (n >= 5) ? n - 4 : 0);
         checkOutput("d4_primed", 32'(primed), (n >= 4) ? 1 : 0);
      end

      // D=1 minimum, modulus 2
      applyStimulus(0, 0, 1, 9'd1);
      for (int n = 1; n <= 10; n++) begin
         applyStimulus(1, DW'(n), 0, 0);
         checkOutput("d1_out_data", 32'(out_data), (n >= 2) ? n - 1 : 0);
      end

      // D=511 maximum, modulus 512, continuous input through several wraps
      applyStimulus(0, 0, 1, 9'd511);
      for (int n = 1; n <= 1300; n++) begin
         applyStimulus(1, DW'(n), 0, 0);
         if (n == 511 || n == 512 || n == 1025 || n == 1300)
            checkOutput("d511_out_data", 32'(out_data), (n >= 512) ? n - 511 : 0);
      end

      // D=3, sparse input: delay counts accepts, idle cycles read 0
      applyStimulus(0, 0, 1, 9'd3);
      for (int n = 0; n < 60; n++) begin
         v = ($urandom_range(0, 2) == 0);
         applyStimulus(v, DW'($urandom), 0, 0);
         if (!v) checkOutput("d3_idle_zero", 32'(out_data), 0);
      end

      // Reconfigure in RUN: D=8 then D=2 with a coincident sample
      applyStimulus(0, 0, 1, 9'd8);
      for (int n = 1; n <= 20; n++) applyStimulus(1, DW'(n), 0, 0);
      checkOutput("reconf_prior_out", 32'(out_data), 12);
      applyStimulus(1, 25'd100, 1, 9'd2);
      checkOutput("reconf_drop", 32'(drop), 1);
      applyStimulus(1, 25'd101, 0, 0);
      checkOutput("reconf_gap1", 32'(out_valid), 0);
      applyStimulus(1, 25'd102, 0, 0);
      checkOutput("reconf_gap2", 32'(out_valid), 0);
      applyStimulus(1, 25'd103, 0, 0);
      checkOutput("reconf_first_out", 32'(out_data), 101);

      // Rejected cfg_len=0 in RUN with D=5
      applyStimulus(0, 0, 1, 9'd5);
      for (int n = 1; n <= 10; n++) applyStimulus(1, DW'(n), 0, 0);
      applyStimulus(1, 25'd11, 1, 9'd0);
      checkOutput("rej_cfg_err", 32'(cfg_err), 1);
      checkOutput("rej_out_data", 32'(out_data), 6);
      applyStimulus(1, 25'd12, 0, 0);
      checkOutput("rej_continue", 32'(out_data), 7);

      // Asynchronous reset between edges
      in_valid = 1'b1;
      in_data  = 25'd13;
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checkOutput("areset_out_valid", 32'(out_valid), 0);
      checkOutput("areset_out_data", 32'(out_data), 0);
      checkOutput("areset_primed", 32'(primed), 0);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1, 25'd14, 0, 0);
      checkOutput("post_reset_drop", 32'(drop), 1);
      checkOutput("post_reset_out_valid", 32'(out_valid), 0);

      // Randomized configurations, gaps and occasional reconfiguration
      for (int c = 0; c < 8; c++) begin
         applyStimulus(0, 0, 1, LW'($urandom_range(1, 20)));
         for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 99) == 0)
               applyStimulus($urandom_range(0, 1) == 1, DW'($urandom), 1, LW'($urandom_range(0, 12)));
            else
               applyStimulus($urandom_range(0, 9) < 7, DW'($urandom), 0, 0);
         end
      end

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/delay_line_ctrl.md
# delay_line_ctrl

Runtime-programmable delay line built on the codebase's dual-port `ram` block, which it instantiates internally. It sequences the RAM's write and read pointers as a circular buffer and tracks fill level. It qualifies output samples so that only data actually written since the last (re)configuration is presented. It sits in the sample pipeline wherever a fixed `shift_reg` is too rigid, e.g. a per-mode delay alignment before FFT or correlator stages.

## Interface
- `DATA_WIDTH`, 25, sample width in bits.
- `MAX_LEN`, 512, RAM depth (power of two, ≥ 4); maximum programmable delay is `MAX_LEN-1`.
- `LEN_W`, `$clog2(MAX_LEN)`, width of pointers and `cfg_len` (localparam).

- `clk`  in  1  single clock for all logic and both RAM ports.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_load`  in  1  one-cycle strobe: latch `cfg_len` as the new delay.
- `cfg_len`  in  LEN_W  requested delay D in samples; legal range 1..MAX_LEN-1.
- `in_valid`  in  1  sample strobe (clock enable); the pipeline advances only on this strobe.
- `in_data`  in  DATA_WIDTH  input sample.
- `out_valid`  out  1  `out_data` holds the sample delayed by D accepted samples.
- `out_data`  out  DATA_WIDTH  delayed sample; forced to 0 when `out_valid`=0.
- `primed`  out  1  high in RUN state (buffer holds D valid samples).
- `cfg_err`  out  1  one-cycle pulse: `cfg_load` was rejected (`cfg_len`=0).
- `drop`  out  1  one-cycle pulse: an `in_valid` sample was discarded (IDLE state, or same cycle as an accepted `cfg_load`).

## Operation
- State machine IDLE / FILL / RUN. Reset → IDLE.
- IDLE: no delay configured; `in_valid` discarded with `drop`=1; RAM not written.
- Accepted `cfg_load` (any state, `cfg_len`≠0): latch D, set modulus M=D+1, set `wr_ptr`=0 and `fill`=0, then go to FILL next cycle. A coincident `in_valid` is dropped.
- Rejected `cfg_load` (`cfg_len`=0): `cfg_err` pulses; state, D, pointers and fill are unchanged; a coincident `in_valid` is processed normally.
- Accepted sample (`in_valid` in FILL/RUN, no accepted `cfg_load`):
  - RAM write at `wr_ptr`, read at `(wr_ptr+1) mod M`; both with enable = accept.
  - `wr_ptr` ← `(wr_ptr+1) mod M`; wrap is explicit compare with D, never relying on power-of-two rollover.
  - Read and write addresses always differ (M ≥ 2), so RAM read/write collision semantics are irrelevant.
- `fill` counts accepted samples since configuration and saturates at D. FILL → RUN on the accept that makes `fill` reach D.
- An accept at cycle t qualifies its output iff `fill`==D before that accept (state RUN at t). The returned sample is the one accepted exactly D accepts earlier.
- `in_valid` low: nothing advances; `out_valid` drops to 0, and `out_data` reads 0.
- No RAM clearing on reconfiguration; stale contents are masked by `fill` gating.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `primed`=0, `cfg_err`=0, `drop`=0, state IDLE, D=0, pointers 0.
- Output latency: 1 clock (RAM read is registered). An accept at edge t yields `out_valid`/`out_data` at edge t+1.
- `out_valid` is a registered copy of (accept && RUN).
- `cfg_err` and `drop` are registered, asserted the cycle after the triggering input.
- `primed` rises the cycle after the D-th accept.
- Continuous `in_valid`: full throughput, one sample per clock.
- Reconfiguring while RUN: `out_valid` for the in-flight sample (accepted the cycle before `cfg_load`) still appears. After that, `out_valid` stays 0 until D new accepts have completed.
- Async reset mid-operation: all outputs clear immediately. After release, the block is in IDLE and requires a new `cfg_load`.

## Test plan
- Reset, `cfg_load` D=4, ramp input 1,2,3… on consecutive cycles → `out_valid` first high one cycle after sample 5 is accepted, with `out_data`=1; thereafter `out_data`=n-4; `primed` high after the 4th accept.
- D=1 (minimum) and D=`MAX_LEN-1`=511 with ramp → outputs n-1 and n-511 respectively; verify pointer wrap at M=2 and M=512 with no glitch.
- D=3 with `in_valid` toggling 1-0-0-1 randomly → delay counted in accepts, not cycles. `out_valid` is 0 on idle cycles, and `out_data` reads 0 when `out_valid` is 0.
- In RUN with D=8, `cfg_load` D=2 together with `in_valid` → `drop` pulses; the old-config output for the prior accept appears. Then `out_valid` stays 0 for 2 accepts, and the next output equals the first sample accepted after reconfiguration.
- `cfg_load` with `cfg_len`=0 in RUN (D=5) → `cfg_err` pulses; output stream continues uninterrupted at delay 5. `in_valid` in IDLE after reset → `drop` pulses, no output.
- Assert `rst_n` low mid-stream asynchronously (between edges) → outputs 0 immediately; after release, `in_valid` produces `drop` until a new `cfg_load`.
